pattern_scan_ctrl: RTL

//   Scan controller for the serial sequence detector. Accepts a DATA_W-bit word
//   on a start handshake and shifts it MSB-first, one bit per clk, through an

---
 rtl/pattern_scan_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl
//   Scan controller for the serial sequence detector. An accepted start
//   captures a DATA_W-bit word and a PAT_W-bit pattern. The word is then
//   shifted MSB-first, one bit per clock, through a PAT_W-bit window. Matches
//   are counted with a saturating counter, the first match position is
//   recorded, and a one-cycle done pulse marks the end of the scan.
//
// Optional feature: define PATTERN_SCAN_OVERLAP_EN to add the cfg_overlap
//   input. When cfg_overlap=1, detection is overlapping. Without the macro,
//   detection is always non-overlapping.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous reset, active high
//   start        scan request; honoured only in IDLE
//   data_in      word to scan, captured on an accepted start
//   cfg_pattern  pattern to find, MSB compared first; captured on start
//   cfg_overlap  (PATTERN_SCAN_OVERLAP_EN only) 1 = overlapping detection
//   busy         high during the DATA_W scan cycles
//   done         one-cycle pulse in the cycle after the last bit
//   match_pulse  one-cycle pulse in the cycle after a completing bit
//   match_cnt    saturating match count for the current/last scan
//   match_found  at least one match seen in the current/last scan
//   first_pos    bit index (0 = MSB) that completed the first match
module pattern_scan_ctrl #(
  parameter int DATA_W = 16,
  parameter int PAT_W  = 4,
  parameter int CNT_W  = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [DATA_W-1:0]         data_in,
  input  logic [PAT_W-1:0]          cfg_pattern,
`ifdef PATTERN_SCAN_OVERLAP_EN
  input  logic                      cfg_overlap,
`endif
  output logic                      busy,
  output logic                      done,
  output logic                      match_pulse,
  output logic [CNT_W-1:0]          match_cnt,
  output logic                      match_found,
  output logic [$clog2(DATA_W)-1:0] first_pos
);

  localparam int POS_W  = $clog2(DATA_W);
  localparam int FILL_W = $clog2(PAT_W + 1);

  localparam logic [POS_W-1:0]  LAST_IDX = POS_W'(DATA_W - 1);
  localparam logic [FILL_W-1:0] FULL     = FILL_W'(PAT_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  logic [DATA_W-1:0]   data_q;    // MSB is the bit consumed this cycle
  logic [PAT_W-1:0]    pat_q;
  logic [PAT_W-1:0]    win;       // most recent bits, newest in LSB
  logic [FILL_W-1:0]   fill;      // valid bits in win, 0..PAT_W
  logic [POS_W-1:0]    bit_idx;   // index of the bit consumed this cycle
  logic                ovl_q;

  logic [PAT_W-1:0]    win_nxt;
  logic [FILL_W-1:0]   fill_nxt;
  logic                hit;

  // Window state including the bit consumed at the coming edge, so a match
  // is detected on the same edge that consumes its last bit.
  always_comb begin
    win_nxt  = {win[PAT_W-2:0], data_q[DATA_W-1]};
    fill_nxt = (fill == FULL) ? fill : fill + 1'b1;
    hit      = (fill_nxt == FULL) && (win_nxt == pat_q);
  end

`ifndef PATTERN_SCAN_OVERLAP_EN
  assign ovl_q = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      match_pulse <= 1'b0;
      match_cnt   <= '0;
      match_found <= 1'b0;
      first_pos   <= '0;
      data_q      <= '0;
      pat_q       <= '0;
      win         <= '0;
      fill        <= '0;
      bit_idx     <= '0;
`ifdef PATTERN_SCAN_OVERLAP_EN
      ovl_q       <= 1'b0;
`endif
    end else begin
      // Pulses default low; each is raised for exactly one cycle below.
      done        <= 1'b0;
      match_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            data_q      <= data_in;
            pat_q       <= cfg_pattern;
`ifdef PATTERN_SCAN_OVERLAP_EN
            ovl_q       <= cfg_overlap;
`endif
            match_cnt   <= '0;
            match_found <= 1'b0;
            first_pos   <= '0;
            win         <= '0;
            fill        <= '0;
            bit_idx     <= '0;
            busy        <= 1'b1;
            state       <= SCAN;
          end
        end
        SCAN: begin
          data_q  <= data_q << 1;
          win     <= win_nxt;
          bit_idx <= bit_idx + 1'b1;
          if (hit) begin
            match_pulse <= 1'b1;
            if (match_cnt != '1)
              match_cnt <= match_cnt + 1'b1;
            if (!match_found) begin
              match_found <= 1'b1;
              first_pos   <= bit_idx;
            end
            // Overlapping detection keeps the full window, so the next bit
            // can complete another match; otherwise refill from scratch.
            fill <= ovl_q ? fill_nxt : '0;
          end else begin
            fill <= fill_nxt;
          end
          if (bit_idx == LAST_IDX) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          // start is not sampled here; a request in this cycle is dropped.
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
